// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit accumulator CPU: opcodes, ALU opcodes and sequencer states.
package cpu_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_JZ    = 4'h9;
   localparam logic [3:0] OP_LOADI = 4'hA;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b1000;
   localparam logic [3:0] ALU_OR  = 4'b1001;
   localparam logic [3:0] ALU_XOR = 4'b1010;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StOper   = 3'd2,
      StExec   = 3'd3,
      StStore  = 3'd4,
      StHalt   = 3'd5
   } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: instruction class flags and the ALU opcode to drive.
module instr_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_mem_rd,
   output logic       is_load,
   output logic       is_store,
   output logic       is_jmp,
   output logic       is_jz,
   output logic       is_loadi,
   output logic       is_halt,
   output logic       illegal,
   output logic [3:0] alu_op
);

   always_comb begin
      is_mem_rd = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_jmp    = 1'b0;
      is_jz     = 1'b0;
      is_loadi  = 1'b0;
      is_halt   = 1'b0;
      illegal   = 1'b0;
      alu_op    = ALU_ADD;
      case (opcode)
         OP_NOP:   ;
         OP_LOAD:  begin is_mem_rd = 1'b1; is_load = 1'b1; end
         OP_STORE: is_store = 1'b1;
         OP_ADD:   begin is_mem_rd = 1'b1; alu_op = ALU_ADD; end
         OP_SUB:   begin is_mem_rd = 1'b1; alu_op = ALU_SUB; end
         OP_AND:   begin is_mem_rd = 1'b1; alu_op = ALU_AND; end
         OP_OR:    begin is_mem_rd = 1'b1; alu_op = ALU_OR;  end
         OP_XOR:   begin is_mem_rd = 1'b1; alu_op = ALU_XOR; end
         OP_JMP:   is_jmp = 1'b1;
         OP_JZ:    is_jz = 1'b1;
         OP_LOADI: is_loadi = 1'b1;
         OP_HALT:  is_halt = 1'b1;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_exec_ctrl.sv
// Multicycle fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Optional ack timeout enabled by defining FEC_ACK_TIMEOUT_EN.
module fetch_exec_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [3:0]        alu_op,
   output logic [15:0]       alu_a,
   output logic [15:0]       alu_b,
   input  logic [15:0]       alu_result,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       ir,
   output logic [15:0]       acc,
   output logic              retire,
   output logic              halted,
   output logic              illegal_op,
   output logic              timeout_err
);

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [15:0]       ir_q;
   logic [15:0]       mbr_q;
   logic [15:0]       acc_q;
   logic              retire_q;
   logic              halted_q;
   logic              illegal_q;

   logic is_mem_rd, is_load, is_store, is_jmp, is_jz, is_loadi, is_halt, illegal;
   logic [ADDR_W-1:0] field;
   logic              req_state;

   assign field = ir_q[ADDR_W-1:0];

   instr_decode u_instr_decode (
      .opcode    (ir_q[15:12]),
      .is_mem_rd (is_mem_rd),
      .is_load   (is_load),
      .is_store  (is_store),
      .is_jmp    (is_jmp),
      .is_jz     (is_jz),
      .is_loadi  (is_loadi),
      .is_halt   (is_halt),
      .illegal   (illegal),
      .alu_op    (alu_op)
   );

`ifdef FEC_ACK_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
   logic [TmoW-1:0] tmo_cnt_q;
   logic            timeout_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StFetch;
         pc_q      <= '0;
         ir_q      <= '0;
         mbr_q     <= '0;
         acc_q     <= '0;
         retire_q  <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
`ifdef FEC_ACK_TIMEOUT_EN
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            StFetch: begin
               if (mem_ack) begin
                  ir_q    <= mem_rdata;
                  pc_q    <= pc_q + 1'b1;
                  state_q <= StDecode;
               end
            end
            StDecode: begin
               if (illegal) begin
                  illegal_q <= 1'b1;
                  halted_q  <= 1'b1;
                  state_q   <= StHalt;
               end else if (is_halt) begin
                  halted_q <= 1'b1;
                  retire_q <= 1'b1;
                  state_q  <= StHalt;
               end else if (is_mem_rd) begin
                  state_q <= StOper;
               end else if (is_store) begin
                  state_q <= StStore;
               end else begin
                  if (is_jmp || (is_jz && (acc_q == 16'h0000))) pc_q <= field;
                  if (is_loadi) acc_q <= {4'h0, ir_q[11:0]};
                  retire_q <= 1'b1;
                  state_q  <= StFetch;
               end
            end
            StOper: begin
               if (mem_ack) begin
                  mbr_q   <= mem_rdata;
                  state_q <= StExec;
               end
            end
            StExec: begin
               acc_q    <= is_load ? mbr_q : alu_result;
               retire_q <= 1'b1;
               state_q  <= StFetch;
            end
            StStore: begin
               if (mem_ack) begin
                  retire_q <= 1'b1;
                  state_q  <= StFetch;
               end
            end
            StHalt:  ;
            default: state_q <= StHalt;
         endcase
`ifdef FEC_ACK_TIMEOUT_EN
         // Overrides the case above only when no ack arrived, so no transfer is lost.
         if (req_state) begin
            if (mem_ack) begin
               tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == TmoLast) begin
               tmo_cnt_q <= '0;
               timeout_q <= 1'b1;
               halted_q  <= 1'b1;
               state_q   <= StHalt;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
         end
`endif
      end
   end

   assign req_state = (state_q == StFetch) || (state_q == StOper) || (state_q == StStore);

   // Gated by reset_n so an abort is visible to memory without waiting for a clock.
   assign mem_req   = reset_n & req_state;
   assign mem_we    = (state_q == StStore);
   assign mem_addr  = (state_q == StFetch) ? pc_q : field;
   assign mem_wdata = acc_q;

   assign alu_a      = acc_q;
   assign alu_b      = mbr_q;
   assign pc         = pc_q;
   assign ir         = ir_q;
   assign acc        = acc_q;
   assign retire     = retire_q;
   assign halted     = halted_q;
   assign illegal_op = illegal_q;

`ifdef FEC_ACK_TIMEOUT_EN
   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Bench for fetch_exec_ctrl: directed programs plus random programs against an ISA-level model.
module tb_fetch_exec_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_drv, sel, ack_drv;
   logic [15:0] rdata_drv;
   int          errors = 0;
   int          checks = 0;

   // Instance A: ADDR_W = 12
   logic        req_a, we_a, ret_a, hlt_a, ill_a, tmo_a;
   logic [11:0] addr_a, pc_a;
   logic [15:0] wd_a, alua_a, alub_a, alur_a, ir_a, acc_a;
   logic [3:0]  aop_a;
   // Instance B: ADDR_W = 4
   logic        req_b, we_b, ret_b, hlt_b, ill_b, tmo_b;
   logic [3:0]  addr_b, pc_b;
   logic [15:0] wd_b, alua_b, alub_b, alur_b, ir_b, acc_b;
   logic [3:0]  aop_b;

   function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      case (op)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b1000: return a & b;
         4'b1001: return a | b;
         4'b1010: return a ^ b;
         default: return 16'h0;
      endcase
   endfunction

   assign alur_a = alu_f(aop_a, alua_a, alub_a);
   assign alur_b = alu_f(aop_b, alua_b, alub_b);

   fetch_exec_ctrl #(.ADDR_W(12), .TIMEOUT_CYC(8)) u_dut (
      .clk(clk), .reset_n(rst_drv & ~sel), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
      .mem_wdata(wd_a), .mem_rdata(rdata_drv), .mem_ack(ack_drv & ~sel), .alu_op(aop_a),
      .alu_a(alua_a), .alu_b(alub_a), .alu_result(alur_a), .pc(pc_a), .ir(ir_a), .acc(acc_a),
      .retire(ret_a), .halted(hlt_a), .illegal_op(ill_a), .timeout_err(tmo_a)
   );

   fetch_exec_ctrl #(.ADDR_W(4), .TIMEOUT_CYC(8)) u_dut4 (
      .clk(clk), .reset_n(rst_drv & sel), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
      .mem_wdata(wd_b), .mem_rdata(rdata_drv), .mem_ack(ack_drv & sel), .alu_op(aop_b),
      .alu_a(alua_b), .alu_b(alub_b), .alu_result(alur_b), .pc(pc_b), .ir(ir_b), .acc(acc_b),
      .retire(ret_b), .halted(hlt_b), .illegal_op(ill_b), .timeout_err(tmo_b)
   );

   logic        o_req, o_we, o_ret, o_hlt, o_ill, o_tmo;
   logic [11:0] o_addr, o_pc;
   logic [15:0] o_wd, o_ir, o_acc;
   assign o_req  = sel ? req_b : req_a;
   assign o_we   = sel ? we_b : we_a;
   assign o_ret  = sel ? ret_b : ret_a;
   assign o_hlt  = sel ? hlt_b : hlt_a;
   assign o_ill  = sel ? ill_b : ill_a;
   assign o_tmo  = sel ? tmo_b : tmo_a;
   assign o_addr = sel ? {8'h00, addr_b} : addr_a;
   assign o_pc   = sel ? {8'h00, pc_b} : pc_a;
   assign o_wd   = sel ? wd_b : wd_a;
   assign o_ir   = sel ? ir_b : ir_a;
   assign o_acc  = sel ? acc_b : acc_a;

   logic [15:0] mem [0:4095];
   logic [15:0] ref_mem [0:4095];

   int exp_rd[$], dut_rd[$], exp_wa[$], exp_wd[$], dut_wa[$], dut_wd[$];
   int exp_cyc, exp_ret, exp_pc, dut_cyc, dut_ret;
   logic [15:0] exp_acc;
   logic        exp_ill;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 16'h0;
         ref_mem[i] = 16'h0;
      end
   endtask

   task automatic put(input int a, input logic [15:0] d);
      mem[a] = d;
      ref_mem[a] = d;
   endtask

   // Instruction-level interpreter; w = wait cycles per memory access.
   task automatic model_run(input int aw, input int w);
      int pc, mask, f;
      logic [15:0] instr, v;
      logic [3:0]  op;
      bit done;
      mask = (1 << aw) - 1;
      pc = 0; exp_acc = 16'h0; exp_cyc = 0; exp_ret = 0; exp_ill = 1'b0; done = 0;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      for (int step = 0; step < 500 && !done; step++) begin
         exp_rd.push_back(pc);
         instr = ref_mem[pc];
         pc = (pc + 1) & mask;
         op = instr[15:12];
         f = int'(instr[11:0]) & mask;
         case (op)
            4'h0: begin exp_cyc += 2 + w; exp_ret++; end
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
               exp_rd.push_back(f);
               v = ref_mem[f];
               case (op)
                  4'h1: exp_acc = v;
                  4'h3: exp_acc = exp_acc + v;
                  4'h4: exp_acc = exp_acc - v;
                  4'h5: exp_acc = exp_acc & v;
                  4'h6: exp_acc = exp_acc | v;
                  default: exp_acc = exp_acc ^ v;
               endcase
               exp_cyc += 4 + 2 * w; exp_ret++;
            end
            4'h2: begin
               ref_mem[f] = exp_acc;
               exp_wa.push_back(f); exp_wd.push_back(int'(exp_acc));
               exp_cyc += 3 + 2 * w; exp_ret++;
            end
            4'h8: begin pc = f; exp_cyc += 2 + w; exp_ret++; end
            4'h9: begin if (exp_acc == 16'h0) pc = f; exp_cyc += 2 + w; exp_ret++; end
            4'hA: begin exp_acc = {4'h0, instr[11:0]}; exp_cyc += 2 + w; exp_ret++; end
            4'hF: begin exp_cyc += 2 + w; exp_ret++; done = 1; end
            default: begin exp_cyc += 2 + w; exp_ill = 1'b1; done = 1; end
         endcase
      end
      exp_pc = pc;
   endtask

   task automatic do_reset(input logic s);
      sel = s; ack_drv = 1'b0; rst_drv = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_low", {31'h0, o_req}, 32'h0);
      rst_drv = 1'b1;
      #1;
      check("rst_state", {o_req, o_ret, o_hlt, o_ill, o_tmo, 27'h0},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 27'h0});
      check("rst_regs", {4'h0, o_addr, o_acc}, 32'h0);
      check("rst_pc_ir", {4'h0, o_pc, o_ir}, 32'h0);
      @(negedge clk);
   endtask

   // Memory responder: acks each request after w wait cycles, random ack noise when idle.
   task automatic dut_run(input int w, input int max_cyc);
      int left;
      bit busy, fin;
      logic [28:0] saved;
      dut_cyc = 0; dut_ret = 0; busy = 0; fin = 0; left = 0; saved = '0;
      dut_rd.delete(); dut_wa.delete(); dut_wd.delete();
      while (!fin) begin
         if (o_ret) dut_ret++;
         if (o_hlt) begin
            fin = 1;
         end else if (dut_cyc >= max_cyc) begin
            check("halt_bound", 32'h0, 32'h1);
            fin = 1;
         end else begin
            if (o_req) begin
               if (!busy) begin
                  busy = 1; left = w; saved = {o_we, o_addr, o_wd};
               end else begin
                  check("req_stable", {3'h0, o_we, o_addr, o_wd}, {3'h0, saved});
               end
               if (left == 0) begin
                  ack_drv = 1'b1;
                  rdata_drv = mem[o_addr];
                  if (o_we) begin
                     mem[o_addr] = o_wd;
                     dut_wa.push_back(int'(o_addr)); dut_wd.push_back(int'(o_wd));
                  end else begin
                     dut_rd.push_back(int'(o_addr));
                  end
                  busy = 0;
               end else begin
                  ack_drv = 1'b0;
                  left--;
               end
            end else begin
               ack_drv = 1'($urandom_range(0, 1));
               rdata_drv = 16'($urandom);
            end
            @(posedge clk);
            dut_cyc++;
            @(negedge clk);
         end
      end
      ack_drv = 1'b0;
   endtask

   task automatic run_and_compare(input string tag, input int aw, input int w);
      model_run(aw, w);
      do_reset(aw == 4);
      dut_run(w, 3000);
      check({tag, "_cycles"}, dut_cyc, exp_cyc);
      check({tag, "_retires"}, dut_ret, exp_ret);
      check({tag, "_acc"}, {16'h0, o_acc}, {16'h0, exp_acc});
      check({tag, "_pc"}, {20'h0, o_pc}, exp_pc);
      check({tag, "_flags"}, {29'h0, o_hlt, o_ill, o_tmo}, {29'h0, 1'b1, exp_ill, 1'b0});
      check({tag, "_nrd"}, dut_rd.size(), exp_rd.size());
      for (int i = 0; i < dut_rd.size() && i < exp_rd.size(); i++)
         check({tag, "_rdaddr"}, dut_rd[i], exp_rd[i]);
      check({tag, "_nwr"}, dut_wa.size(), exp_wa.size());
      for (int i = 0; i < dut_wa.size() && i < exp_wa.size(); i++) begin
         check({tag, "_wraddr"}, dut_wa[i], exp_wa[i]);
         check({tag, "_wrdata"}, dut_wd[i], exp_wd[i]);
      end
      repeat (2) @(negedge clk);
      check({tag, "_halt_noreq"}, {31'h0, o_req}, 32'h0);
   endtask

   initial begin
      int len, k, w;
      logic [3:0] op;
      sel = 1'b0; rst_drv = 1'b0; ack_drv = 1'b0; rdata_drv = 16'h0;

      clear_mem();
      put(0, 16'hA005); put(1, 16'hF000);
      run_and_compare("loadi_halt", 12, 0);

      clear_mem();
      put(0, 16'h1010); put(1, 16'h3011); put(2, 16'h2012); put(3, 16'hF000);
      put(16'h10, 16'h7FFF); put(16'h11, 16'h0002);
      run_and_compare("ld_add_st", 12, 0);
      check("ld_add_st_mem", {16'h0, mem[16'h12]}, 32'h8001);

      clear_mem();
      put(0, 16'h1010); put(1, 16'h3011); put(2, 16'h2012); put(3, 16'hF000);
      put(16'h10, 16'h7FFF); put(16'h11, 16'h0002);
      run_and_compare("wait3", 12, 3);

      clear_mem();
      put(0, 16'h9020); put(16'h20, 16'hF000);
      run_and_compare("jz_taken", 12, 0);

      clear_mem();
      put(0, 16'hA001); put(1, 16'h9020); put(2, 16'hF000);
      run_and_compare("jz_not_taken", 12, 1);

      clear_mem();
      put(0, 16'hC000);
      run_and_compare("illegal", 12, 0);

      clear_mem();
      put(0, 16'h900E); put(14, 16'hA001); put(15, 16'h0000); put(1, 16'hF000);
      run_and_compare("pc_wrap", 4, 0);

      for (int p = 0; p < 12; p++) begin
         clear_mem();
         for (int i = 0; i < 16; i++) put(16'h100 + i, 16'($urandom));
         len = $urandom_range(4, 12);
         for (int i = 0; i < len - 1; i++) begin
            k = $urandom_range(0, 10);
            case (k)
               0: op = 4'h1;  1: op = 4'h2;  2: op = 4'h3;  3: op = 4'h4;
               4: op = 4'h5;  5: op = 4'h6;  6: op = 4'h7;  7: op = 4'hA;
               8: op = 4'h0;  9: op = 4'h9;  default: op = 4'h8;
            endcase
            if ((op == 4'h8 || op == 4'h9) && (i + 2 > len - 1)) op = 4'h0;
            if (op == 4'h8 || op == 4'h9)
               put(i, {op, 12'(i + 2)});
            else if (op == 4'hA)
               put(i, {op, 12'($urandom)});
            else
               put(i, {op, 12'h100 + 12'($urandom_range(0, 15))});
         end
         put(len - 1, 16'hF000);
         w = $urandom_range(0, 2);
         run_and_compare("random", 12, w);
      end

      // Abort mid-fetch, then ack starvation.
      clear_mem();
      put(0, 16'h0000);
      sel = 1'b0; rst_drv = 1'b0; ack_drv = 1'b0;
      @(negedge clk);
      rst_drv = 1'b1;
      repeat (3) @(negedge clk);
      check("stall_req", {19'h0, o_req, o_addr}, {19'h0, 1'b1, 12'h000});
      rst_drv = 1'b0;
      #1;
      check("abort_req_drop", {31'h0, o_req}, 32'h0);
      @(negedge clk);
      rst_drv = 1'b1;
      #1;
      check("abort_restart", {19'h0, o_req, o_addr}, {19'h0, 1'b1, 12'h000});
      @(negedge clk);
`ifdef FEC_ACK_TIMEOUT_EN
      repeat (6) @(negedge clk);
      check("tmo_before", {30'h0, o_req, o_tmo}, {30'h0, 1'b1, 1'b0});
      @(negedge clk);
      check("tmo_after", {29'h0, o_req, o_tmo, o_hlt}, {29'h0, 1'b0, 1'b1, 1'b1});
      check("tmo_no_illegal", {31'h0, o_ill}, 32'h0);
`else
      repeat (20) @(negedge clk);
      check("no_tmo_wait", {29'h0, o_req, o_tmo, o_hlt}, {29'h0, 1'b1, 1'b0, 1'b0});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
